// File: rtl/user_module.sv
// 8-bit serial-in/parallel-out shift register tile with hold, reverse shift,
// synchronous clear and parallel load from the bidirectional bus.
module user_module (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       w_din;
    logic       w_hold;
    logic       w_reverse;
    logic       w_load;
    logic       w_clear;
    logic       w_unused;
    logic [7:0] w_q_next;
    logic [7:0] r_q;

    assign w_din     = ui_in[0];
    assign w_hold    = ui_in[1];
    assign w_reverse = ui_in[2];
    assign w_load    = ui_in[3];
    assign w_clear   = ui_in[4];
    assign w_unused  = ^ui_in[7:5];

    // Priority: enable, clear, load, hold, then shift in the selected direction.
    always_comb begin
        // NOTE: default assignment first so every path drives w_q_next and no latch is inferred.
        w_q_next = r_q;
        if (!ena) begin
            w_q_next = r_q;
        end else if (w_clear) begin
            w_q_next = 8'h00;
        end else if (w_load) begin
            w_q_next = uio_in;
        end else if (w_hold) begin
            w_q_next = r_q;
        end else if (!w_reverse) begin
            w_q_next = {r_q[6:0], w_din};
        end else begin
            w_q_next = {w_din, r_q[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked logic so every flop samples pre-edge values.
        if (rst) begin
            r_q <= 8'h00;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign uo_out  = r_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_user_module.sv
// Self-checking bench for user_module: directed scenarios followed by
// randomized control/data traffic compared against an arithmetic model.
module tb_user_module;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q = 8'h00;

    user_module dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next register value computed from the behavioural rules with plain arithmetic.
    function automatic logic [7:0] model(input logic [7:0] q, input logic en,
                                         input logic [7:0] ui, input logic [7:0] ld);
        int v;
        v = int'(q);
        if (!en)        return q;
        if (ui[4])      return 8'h00;
        if (ui[3])      return ld;
        if (ui[1])      return q;
        if (!ui[2])     v = (v * 2 + int'(ui[0])) % 256;
        else            v = v / 2 + int'(ui[0]) * 128;
        return v[7:0];
    endfunction

    // One clock edge: predict, clock, then sample 1ns after the edge.
    task automatic tick(input string tag);
        exp_q = model(exp_q, ena, ui_in, uio_in);
        @(posedge clk);
        #1;
        check(tag, uo_out, exp_q);
        check({tag, "_oe"}, uio_oe, 8'h00);
        check({tag, "_uio_out"}, uio_out, 8'h00);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q = 8'h00;
        check(tag, uo_out, 8'h00);
        check({tag, "_oe"}, uio_oe, 8'h00);
        check({tag, "_uio_out"}, uio_out, 8'h00);
        #2;
        rst = 1'b0;
    endtask

    logic [7:0] pattern;

    initial begin
        // Reset asserted with no clock edge seen yet
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", uo_out, 8'h00);
        check("reset_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        exp_q = 8'h00;
        ena = 1'b1;
        ui_in = 8'h00;
        tick("idle_after_reset");

        // Walking one
        ui_in = 8'h01;
        tick("walk_1");
        ui_in = 8'h00;
        for (int i = 2; i <= 9; i++) begin
            tick($sformatf("walk_%0d", i));
        end
        check("walk_expected_zero", uo_out, 8'h00);

        // Serial pattern 1,0,1,1,0,1,1,0 lands as 10110110
        pattern = 8'b1011_0110;
        for (int i = 7; i >= 0; i--) begin
            ui_in = {7'b0, pattern[i]};
            tick("pattern_shift");
        end
        check("pattern_final", uo_out, 8'hB6);

        // Async reset mid-run after a load
        ui_in = 8'h08;
        uio_in = 8'hB6;
        tick("load_b6");
        ui_in = 8'h00;
        async_reset("reset_mid_run");

        // Controls
        ui_in = 8'h08;
        uio_in = 8'hA5;
        tick("load_a5");
        check("load_a5_value", uo_out, 8'hA5);
        ui_in = 8'h03;
        uio_in = 8'h3C;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_value", uo_out, 8'hA5);
        ui_in = 8'h04;
        tick("reverse");
        check("reverse_value", uo_out, 8'h52);
        ui_in = 8'h1A;
        uio_in = 8'hFF;
        tick("clear_wins");
        check("clear_value", uo_out, 8'h00);

        // Enable low freezes state
        ui_in = 8'h08;
        uio_in = 8'h5A;
        tick("load_5a");
        ena = 1'b0;
        ui_in = 8'h01;
        for (int i = 0; i < 4; i++) tick("ena_low");
        check("ena_low_value", uo_out, 8'h5A);
        ena = 1'b1;

        // Mid-cycle input glitch with no edge in between has no effect
        ui_in = 8'h10;
        #2;
        ui_in = 8'h08;
        #2;
        ui_in = 8'h00;
        #1;
        check("mid_cycle_glitch", uo_out, exp_q);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_reset");
            end else begin
                ena = ($urandom_range(0, 7) != 0);
                ui_in = 8'($urandom);
                ui_in[4] = ($urandom_range(0, 11) == 0);
                ui_in[3] = ($urandom_range(0, 7) == 0);
                ui_in[1] = ($urandom_range(0, 3) == 0);
                uio_in = 8'($urandom);
                tick("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
